// File: rtl/interrupt_sequencer.sv
// Purpose: latch external IRQ lines, pick the lowest-index enabled one and hand it to the pipeline at a safe point.
// Latency: interrupt pulses 2 cycles after an unmasked irq_i rises on an idle, unstalled pipeline.
// Backpressure: stall_pipl / branch_hazard / mret_type defer the take; no new take until the handler's MRET retires.
//
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   irq_i, irq_mask_i     raw level requests and per-line enables
//   global_ie_i           global interrupt enable
//   stall_pipl, load_hazard, branch_hazard, mret_type   pipeline status
//   epc_i                 PC of the oldest non-flushed instruction
//   interrupt, mepc_we_o  one-cycle take pulse and mepc write strobe
//   irq_cause_o, mepc_o   taken line index and captured EPC
//   irq_ack_o             one-hot source clear for the taken line
//   in_handler_o          high while the handler runs
module interrupt_sequencer #(
    parameter int NUM_IRQ = 8,
    parameter int CAUSE_W = 5,
    parameter int XLEN    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_mask_i,
    input  logic               global_ie_i,
    input  logic               stall_pipl,
    input  logic               load_hazard,
    input  logic               branch_hazard,
    input  logic               mret_type,
    input  logic [XLEN-1:0]    epc_i,
    output logic               interrupt,
    output logic [CAUSE_W-1:0] irq_cause_o,
    output logic               mepc_we_o,
    output logic [XLEN-1:0]    mepc_o,
    output logic [NUM_IRQ-1:0] irq_ack_o,
    output logic               in_handler_o
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT_SAFE  = 2'd1;
    localparam logic [1:0] TAKE       = 2'd2;
    localparam logic [1:0] IN_HANDLER = 2'd3;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [NUM_IRQ-1:0] pending_q;
    logic [CAUSE_W-1:0] cause_q;
    logic [XLEN-1:0]    mepc_q;

    logic [NUM_IRQ-1:0] eligible;
    logic [CAUSE_W-1:0] winner;
    logic               safe;
    logic               load_take;
    logic               take_fire;
    logic [NUM_IRQ-1:0] ack_vec;

    // The pipeline controller's interrupt clear already overrides a load-use
    // bubble, so load_hazard never needs to hold off a take.
    logic unused_load_hazard;
    assign unused_load_hazard = load_hazard;

    assign safe     = ~stall_pipl & ~branch_hazard & ~mret_type;
    assign eligible = pending_q & irq_mask_i & {NUM_IRQ{global_ie_i}};

    // Lowest index wins: scan from the top so the lowest set bit is written last.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = CAUSE_W'(i);
            end
        end
    end

    // Decision taken in IDLE or WAIT_SAFE; cause and EPC are frozen here.
    assign load_take = ((state_q == IDLE) || (state_q == WAIT_SAFE)) &&
                       (eligible != '0) && safe;

    // The take is registered, but still qualified by the live safe term so a
    // stall arriving on the TAKE cycle cancels the whole take (pulse, strobe
    // and ack together) instead of letting a partial take through.
    assign take_fire = (state_q == TAKE) && safe;
    assign ack_vec   = take_fire ? (NUM_IRQ'(1) << cause_q) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WAIT_SAFE: begin
                if (eligible == '0) begin
                    state_d = IDLE;
                end else if (safe) begin
                    state_d = TAKE;
                end else begin
                    state_d = WAIT_SAFE;
                end
            end
            TAKE: begin
                state_d = safe ? IN_HANDLER : WAIT_SAFE;
            end
            IN_HANDLER: begin
                // A stalled MRET has not retired yet; wait for the unstalled cycle.
                if (mret_type && !stall_pipl) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            cause_q   <= '0;
            mepc_q    <= '0;
        end else begin
            state_q   <= state_d;
            // Clear beats set; a line still held high re-latches next cycle.
            pending_q <= (pending_q | irq_i) & ~ack_vec;
            if (load_take) begin
                cause_q <= winner;
                mepc_q  <= epc_i;
            end
        end
    end

    assign interrupt    = take_fire;
    assign mepc_we_o    = take_fire;
    assign irq_ack_o    = ack_vec;
    assign irq_cause_o  = cause_q;
    assign mepc_o       = mepc_q;
    assign in_handler_o = (state_q == IN_HANDLER);

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Purpose: self-checking bench for interrupt_sequencer with directed scenarios and random traffic.
// Latency: each step drives inputs after negedge, checks 1 time unit later, updates the model at posedge.
// Backpressure: stall, branch and MRET hazards are driven directly and predicted by the model.
module tb_interrupt_sequencer;

    localparam int N  = 8;
    localparam int CW = 5;
    localparam int XL = 32;

    logic          clk;
    logic          reset;
    logic [N-1:0]  irq;
    logic [N-1:0]  mask;
    logic          gie;
    logic          stall;
    logic          load_hz;
    logic          branch;
    logic          mret;
    logic [XL-1:0] epc;
    logic          interrupt;
    logic [CW-1:0] irq_cause_o;
    logic          mepc_we_o;
    logic [XL-1:0] mepc_o;
    logic [N-1:0]  irq_ack_o;
    logic          in_handler_o;

    interrupt_sequencer #(.NUM_IRQ(N), .CAUSE_W(CW), .XLEN(XL)) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_i        (irq),
        .irq_mask_i   (mask),
        .global_ie_i  (gie),
        .stall_pipl   (stall),
        .load_hazard  (load_hz),
        .branch_hazard(branch),
        .mret_type    (mret),
        .epc_i        (epc),
        .interrupt    (interrupt),
        .irq_cause_o  (irq_cause_o),
        .mepc_we_o    (mepc_we_o),
        .mepc_o       (mepc_o),
        .irq_ack_o    (irq_ack_o),
        .in_handler_o (in_handler_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: requests accumulate in a pending set; when no handler
    // is active and nothing is scheduled, the lowest enabled pending line is
    // scheduled on a safe cycle and delivered on the next cycle if it is
    // still safe. Delivery starts the handler; an unstalled MRET ends it.
    logic [N-1:0]  m_pend;
    bit            m_sched;
    bit            m_hdl;
    logic [CW-1:0] m_cause;
    logic [XL-1:0] m_mepc;

    bit            last_int;
    logic [CW-1:0] last_cause;
    logic [N-1:0]  last_ack;
    logic [XL-1:0] last_mepc;

    function automatic logic [CW-1:0] lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return CW'(i);
        end
        return '0;
    endfunction

    task automatic step();
        bit           safe;
        bit           fire;
        logic [N-1:0] elig;
        logic [N-1:0] ack;
        #1;
        safe = !stall && !branch && !mret;
        fire = m_sched && safe;
        ack  = fire ? (N'(1) << m_cause) : '0;
        check("interrupt", interrupt, fire);
        check("mepc_we", mepc_we_o, fire);
        check("irq_ack", irq_ack_o, ack);
        check("in_handler", in_handler_o, m_hdl);
        if (fire) begin
            check("cause", irq_cause_o, m_cause);
            check("mepc", mepc_o, m_mepc);
        end
        last_int   = interrupt;
        last_cause = irq_cause_o;
        last_ack   = irq_ack_o;
        last_mepc  = mepc_o;
        @(posedge clk);
        if (reset) begin
            m_pend  = '0;
            m_sched = 0;
            m_hdl   = 0;
            m_cause = '0;
            m_mepc  = '0;
        end else begin
            elig = m_pend & mask & {N{gie}};
            if (m_sched) begin
                m_sched = 0;
                if (safe) m_hdl = 1;
            end else if (m_hdl) begin
                if (mret && !stall) m_hdl = 0;
            end else if (elig != '0 && safe) begin
                m_sched = 1;
                m_cause = lowest(elig);
                m_mepc  = epc;
            end
            m_pend = (m_pend | irq) & ~ack;
        end
        @(negedge clk);
    endtask

    task automatic wait_pulse(input int max, output int n);
        n = 0;
        last_int = 0;
        while (!last_int && n < max) begin
            step();
            n++;
        end
        check("pulse_seen", last_int, 1);
    endtask

    task automatic finish_handler();
        irq  = '0;
        mret = 1'b1;
        step();
        mret = 1'b0;
        step();
    endtask

    int n;
    int pulses;

    initial begin
        reset = 1'b1; irq = '0; mask = 8'hFF; gie = 1'b1; stall = 1'b0;
        load_hz = 1'b0; branch = 1'b0; mret = 1'b0; epc = 32'h0000_0100;
        m_pend = '0; m_sched = 0; m_hdl = 0; m_cause = '0; m_mepc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step();
        check("rst_interrupt", interrupt, 0);
        check("rst_ack", irq_ack_o, 0);
        check("rst_in_handler", in_handler_o, 0);
        check("rst_cause", irq_cause_o, 0);
        check("rst_mepc", mepc_o, 0);
        reset = 1'b0;
        step();

        // Basic take: latency, cause, ack, mepc.
        irq = 8'h04;
        wait_pulse(10, n);
        check("s1_latency", n, 3);
        check("s1_cause", last_cause, 2);
        check("s1_ack", last_ack, 8'h04);
        check("s1_mepc", last_mepc, 32'h0000_0100);
        irq = '0;
        step();
        check("s1_in_handler", in_handler_o, 1);
        finish_handler();

        // Two lines at once: lowest first, the other after MRET.
        irq = 8'h84;
        wait_pulse(10, n);
        check("s2_first_cause", last_cause, 2);
        irq = 8'h80;
        repeat (3) step();
        mret = 1'b1;
        step();
        mret = 1'b0;
        wait_pulse(10, n);
        check("s2_after_mret_gap", n, 2);
        check("s2_second_cause", last_cause, 7);
        finish_handler();

        // Stall defers the take.
        stall = 1'b1; irq = 8'h10; pulses = 0;
        repeat (5) begin step(); pulses += int'(last_int); end
        check("s3_no_pulse_stall", pulses, 0);
        stall = 1'b0;
        wait_pulse(10, n);
        check("s3_stall_release", n, 2);
        check("s3_cause", last_cause, 4);
        finish_handler();

        // Branch flush defers the take.
        branch = 1'b1; irq = 8'h20; pulses = 0;
        repeat (3) begin step(); pulses += int'(last_int); end
        check("s3_no_pulse_branch", pulses, 0);
        branch = 1'b0;
        wait_pulse(10, n);
        check("s3_branch_release", n, 2);
        check("s3_branch_cause", last_cause, 5);
        finish_handler();

        // Masked line stays pending and is taken once unmasked.
        mask = 8'hF7; irq = 8'h08; pulses = 0;
        repeat (4) begin step(); pulses += int'(last_int); end
        irq = '0;
        repeat (2) begin step(); pulses += int'(last_int); end
        check("s4_masked_no_pulse", pulses, 0);
        mask = 8'hFF;
        wait_pulse(10, n);
        check("s4_unmask_latency", n, 2);
        check("s4_cause", last_cause, 3);
        finish_handler();

        // Global enable dropped while waiting: back to idle, no pulse.
        stall = 1'b1; irq = 8'h02; pulses = 0;
        repeat (3) begin step(); pulses += int'(last_int); end
        gie = 1'b0;
        step(); pulses += int'(last_int);
        stall = 1'b0; irq = '0;
        repeat (3) begin step(); pulses += int'(last_int); end
        check("s4_gie_off_no_pulse", pulses, 0);
        gie = 1'b1;
        wait_pulse(10, n);
        check("s4_gie_on_latency", n, 2);
        check("s4_gie_cause", last_cause, 1);

        // Stalled MRET is ignored; unstalled one ends the handler.
        step();
        mret = 1'b1; stall = 1'b1;
        step();
        check("s5_stalled_mret_stays", in_handler_o, 1);
        stall = 1'b0;
        step();
        mret = 1'b0;
        check("s5_mret_leaves", in_handler_o, 0);
        step();

        // Reset on the TAKE cycle wipes everything.
        irq = 8'h01;
        step();
        step();
        reset = 1'b1;
        #1;
        check("s6_pulse_present", interrupt, 1);
        step();
        reset = 1'b0; irq = '0;
        #1;
        check("s6_interrupt_cleared", interrupt, 0);
        check("s6_ack_cleared", irq_ack_o, 0);
        check("s6_in_handler_cleared", in_handler_o, 0);
        pulses = 0;
        repeat (4) begin step(); pulses += int'(last_int); end
        check("s6_pending_lost", pulses, 0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset   = ($urandom_range(0, 299) == 0);
            irq     = N'($urandom & $urandom & $urandom);
            mask    = ($urandom_range(0, 9) == 0) ? N'($urandom) : 8'hFF;
            gie     = ($urandom_range(0, 9) != 0);
            stall   = ($urandom_range(0, 3) == 0);
            branch  = ($urandom_range(0, 6) == 0);
            load_hz = $urandom_range(0, 1) == 1;
            mret    = ($urandom_range(0, 4) == 0);
            epc     = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Upstream of the pipeline hazard/flush controller; sole source of its `interrupt` input.
- Latches external interrupt requests and arbitrates by fixed priority.
- Waits for a safe pipeline point, then issues a one-cycle `interrupt` pulse with cause and EPC capture strobes.
- Blocks further interrupts until the handler's MRET retires.

Parameters:
- NUM_IRQ, 8, number of external interrupt lines (1..32).
- CAUSE_W, 5, width of the cause index output; must satisfy 2^CAUSE_W >= NUM_IRQ.
- XLEN, 32, PC width.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- irq_i  in  NUM_IRQ  raw request lines, level, already synchronised.
- irq_mask_i  in  NUM_IRQ  per-line enable (mie); 1 = enabled.
- global_ie_i  in  1  global interrupt enable (mstatus.MIE).
- stall_pipl  in  1  pipeline stall (same signal the pipeline controller consumes).
- load_hazard  in  1  load-use hazard.
- branch_hazard  in  1  taken branch/jump flush in progress.
- mret_type  in  1  MRET in EXE; retires this cycle unless stalled.
- epc_i  in  XLEN  PC of the oldest non-flushed instruction (MEM stage).
- interrupt  out  1  one-cycle take pulse to the pipeline controller.
- irq_cause_o  out  CAUSE_W  index of the taken line; valid while `interrupt` = 1.
- mepc_we_o  out  1  write strobe for mepc; equals `interrupt`.
- mepc_o  out  XLEN  epc_i sampled on the take cycle.
- irq_ack_o  out  NUM_IRQ  one-hot, one cycle, clears the source of the taken line.
- in_handler_o  out  1  high from take until MRET retire.

Behaviour:
- All state is updated on posedge clk.
- Reset values:
  - State = IDLE.
  - pending = 0.
  - interrupt, mepc_we_o, irq_ack_o, in_handler_o = 0.
  - irq_cause_o = 0, mepc_o = 0.
- Pending latch:
  - pending[i] is set when irq_i[i] = 1.
  - pending[i] is cleared only on the cycle its irq_ack_o[i] is asserted.
  - Set and clear on the same cycle resolve to clear; a still-high line re-sets pending on the next cycle.
- Eligibility and priority:
  - eligible = pending & irq_mask_i, gated by global_ie_i.
  - Lowest index wins.
  - Masking a line while pending keeps its pending bit but removes it from arbitration.
- safe = ~stall_pipl & ~branch_hazard & ~mret_type. load_hazard does not block, because the pipeline controller's interrupt clear overrides the bubble.
- IDLE:
  - If eligible != 0 and safe: go to TAKE.
  - If eligible != 0 and not safe: go to WAIT_SAFE.
  - Otherwise stay in IDLE.
- WAIT_SAFE:
  - If eligible == 0 (masked or global_ie dropped): return to IDLE.
  - Else if safe: go to TAKE.
  - Else stay.
  - The winner is re-arbitrated every cycle.
- TAKE (exactly one cycle):
  - interrupt = 1 and mepc_we_o = 1.
  - irq_cause_o = registered winner index.
  - mepc_o = epc_i registered on the TAKE-entry cycle.
  - irq_ack_o = onehot(winner).
  - Next state = IN_HANDLER.
  - Outputs are registered, so the pulse appears the cycle after the decision.
  - The decision is rechecked in TAKE: if safe dropped (stall_pipl rose), suppress all outputs and go back to WAIT_SAFE; no partial take.
- IN_HANDLER:
  - in_handler_o = 1; no nesting.
  - On mret_type = 1 and stall_pipl = 0: go to IDLE, and in_handler_o drops the next cycle.
  - mret_type with stall_pipl = 1 is ignored until the unstalled cycle.
- Latency: an unmasked request on an idle, unstalled pipeline gives `interrupt` two cycles after irq_i rises (pending latch, then TAKE).
- Simultaneous events:
  - MRET retire in IN_HANDLER with eligible != 0: go to IDLE first; the next take needs ≥2 cycles, guaranteeing one handler-return instruction fetch.
  - branch_hazard together with a new request: wait in WAIT_SAFE.
- Reset mid-operation (any state, including TAKE): outputs are forced to reset values the next cycle and all pending bits are lost.
- mret_type seen outside IN_HANDLER: no effect.

Test Plan:
- Reset then irq_i = 0x04, mask = 0xFF, global_ie = 1, no hazards → interrupt = 1 exactly one cycle, two cycles after irq_i rises; irq_cause_o = 2; irq_ack_o = 0x04; mepc_o = epc_i (0x0000_0100); in_handler_o = 1 afterwards.
- irq_i = 0x84 on the same cycle → cause = 2 taken first. Drop line 2, then MRET retires → line 7 taken with cause = 7, no earlier than 2 cycles after MRET.
- Request while stall_pipl = 1 for 5 cycles → no interrupt during the stall; pulse appears 1 cycle after stall_pipl falls. Repeat with branch_hazard held 3 cycles → same deferral.
- Request with irq_mask_i[3] = 0 → no take; pending held. Set mask bit → take with cause = 3. Clear global_ie in WAIT_SAFE → return to IDLE, no pulse.
- In IN_HANDLER: mret_type = 1 with stall_pipl = 1 → stays in handler. Next cycle mret_type = 1, stall = 0 → in_handler_o = 0 one cycle later.
- Assert reset during the TAKE cycle → interrupt, irq_ack_o, and in_handler_o are all 0 the following cycle; pending = 0.
